dft_accumulation: RTL and testbench
===================================

# dft_accumulation

Streaming multi-bin DFT accumulator for the I/Q spectral-analysis path. Each valid complex sample is windowed, multiplied by a per-bin complex oscillator value supplied by an upstream oscillator bank, and accumulated into NUM_BINS complex accumulators. At the end of a frame, marked by `last_sample_i`, the block presents the accumulated bin values and pulses `valid_o`.

## Interface
- IQ_WIDTH, 16: signed I/Q sample width.
- WINDOW_WIDTH, 16: signed window coefficient width, Q1.(WINDOW_WIDTH-1).
- ACCUM_WIDTH, 48: signed accumulator width per real/imag part.
- OSC_WIDTH, 27: signed oscillator width, Q2.(OSC_WIDTH-2); 1.0 = 2^25.
- NUM_BINS, 24: number of frequency bins.
- SAMPLE_COUNT_WIDTH, 16: width of the internal accepted-sample counter.

One clock; reset is asynchronous and active-high.

- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  begin a new frame; clears accumulators
- sample_valid_i  in  1  sample/window/oscillator inputs valid this cycle
- last_sample_i  in  1  qualifies the final sample of the frame (only with sample_valid_i)
- i_sample_i, q_sample_i  in  IQ_WIDTH  signed I/Q sample
- window_coeff_i  in  WINDOW_WIDTH  signed window coefficient
- W_real_i, W_imag_i  in  OSC_WIDTH × [NUM_BINS]  per-bin oscillator (twiddle) value
- A_real_o, A_imag_o  out  ACCUM_WIDTH × [NUM_BINS]  accumulated bin values
- valid_o  out  1  one-cycle pulse: frame result ready
- busy_o  out  1  frame in progress (accepting or draining)

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
  - IDLE + start_i → ACCUM.
  - ACCUM + accepted last sample → DRAIN.
  - DRAIN, after the final accumulate → IDLE with valid_o pulse.
  - start_i in any state clears accumulators, pipeline and counter, then enters ACCUM (restart).
- A sample is accepted only when state = ACCUM, sample_valid_i = 1 and start_i = 0.
  - Inputs are ignored in IDLE and DRAIN.
  - If start_i and sample_valid_i are both high, start_i wins and the sample is dropped.
- Windowing: xi = (i·w) >>> (WINDOW_WIDTH-1); xq = (q·w) >>> (WINDOW_WIDTH-1). Result is 17-bit signed, arithmetic shift (floor).
- Per bin k, complex product P = (xi + j·xq)(Wr + j·Wi):
  - Pr = (xi·Wr − xq·Wi) >>> (OSC_WIDTH-2)
  - Pi = (xi·Wi + xq·Wr) >>> (OSC_WIDTH-2)
  - Full-precision sums before the shift; floor.
- Accumulation: A_k += P, sign-extended to ACCUM_WIDTH, two's-complement wrap, no saturation.
- Sample counter counts accepted samples and saturates. If it reaches 2^SAMPLE_COUNT_WIDTH−1, that sample is treated as last.
- A_real_o and A_imag_o hold their values after a frame until the next start_i, which zeroes them.
- Reset: all accumulators and outputs = 0, busy_o = 0, valid_o = 0, state IDLE. Reset mid-frame aborts the frame with no valid_o.

## Timing
- start_i sampled at edge S: busy_o = 1 and A = 0 from the cycle after S.
- Pipeline is 3 registered stages:
  - E0: windowed sample registered.
  - E1: per-bin products registered.
  - E2: accumulator updated.
- Last sample accepted at edge E0: accumulators final at E0+2. valid_o is high for exactly the one cycle after E0+2, and busy_o falls at the same edge.
- Bubbles in sample_valid_i are allowed and only delay completion.
- Throughput: one sample per cycle.

## Structure
- Package dft_pkg holds:
  - width constants (IQ/WINDOW/OSC/ACCUM/NUM_BINS defaults)
  - the FSM state enum
  - derived widths: windowed = IQ_WIDTH+1; product = windowed+OSC_WIDTH+1
- Sub-module dft_bin_mac, instantiated NUM_BINS times: complex multiply (E1) plus accumulate (E2) with synchronous clear.
- The top level owns the FSM, windowing stage, last-flag pipeline and counter.

## Test plan
- Reset: with rst_i held, all A outputs = 0, busy_o = 0, valid_o = 0. Sample inputs without start_i → no change, no valid_o.
- DC, bin 0: I = 0x4000, Q = 0, w = 0x7FFF, Wr = 0x2000000, Wi = 0, 4 samples → A_real[0] = 65532 (4·16383), A_imag[0] = 0. valid_o one cycle, 3 cycles after the last sample.
- Rotation by j: I = 0, Q = 1000, w = 0x7FFF, Wr = 0, Wi = 0x2000000, 1 sample → A_real = −999 (0xFFFFFFFFFC19), A_imag = 0.
- 256-sample windowed tone across all 24 bins, with oscillators from the reference model → every bin within ±100 LSB of the bit-exact golden values.
- Gapped sample_valid_i (every other cycle) → results identical to the continuous-stream case.
- Back-to-back frames, plus start_i mid-frame → accumulators restart from 0. The second frame's results are unaffected by the first; a frame aborted by start_i produces no valid_o.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared widths and FSM state type for the streaming multi-bin DFT accumulator.
package dft_pkg;

    localparam int unsigned IQ_W     = 16;
    localparam int unsigned WIN_W    = 16;
    localparam int unsigned OSC_W    = 27;
    localparam int unsigned ACC_W    = 48;
    localparam int unsigned BINS     = 24;
    localparam int unsigned CNT_W    = 16;

    // Windowed sample keeps one extra bit; product sum needs one guard bit.
    localparam int unsigned XWIN_W   = IQ_W + 1;
    localparam int unsigned PROD_W   = XWIN_W + OSC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/dft_bin_mac.sv
// One frequency bin: latch oscillator with the sample, complex multiply (E1), accumulate (E2).
module dft_bin_mac
    import dft_pkg::*;
#(
    parameter int unsigned XW          = XWIN_W,
    parameter int unsigned OSC_WIDTH   = OSC_W,
    parameter int unsigned ACCUM_WIDTH = ACC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          load,
    input  logic                          acc_en,
    input  logic signed [XW-1:0]          xi,
    input  logic signed [XW-1:0]          xq,
    input  logic signed [OSC_WIDTH-1:0]   w_real,
    input  logic signed [OSC_WIDTH-1:0]   w_imag,
    output logic signed [ACCUM_WIDTH-1:0] acc_real,
    output logic signed [ACCUM_WIDTH-1:0] acc_imag
);

    localparam int unsigned PW    = XW + OSC_WIDTH + 1;
    localparam int unsigned SHIFT = OSC_WIDTH - 2;
    localparam int unsigned RW    = PW - SHIFT;

    logic signed [OSC_WIDTH-1:0] wr_q, wi_q;
    logic signed [PW-1:0]        pr_full, pi_full;
    logic signed [RW-1:0]        pr_q, pi_q;

    // Full-precision complex product; rounding happens only in the final shift.
    always_comb begin
        pr_full = PW'(xi) * PW'(wr_q) - PW'(xq) * PW'(wi_q);
        pi_full = PW'(xi) * PW'(wi_q) + PW'(xq) * PW'(wr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= '0;
            wi_q     <= '0;
            pr_q     <= '0;
            pi_q     <= '0;
            acc_real <= '0;
            acc_imag <= '0;
        end else begin
            if (load) begin
                wr_q <= w_real;
                wi_q <= w_imag;
            end
            pr_q <= RW'(pr_full >>> SHIFT);
            pi_q <= RW'(pi_full >>> SHIFT);
            if (clear) begin
                acc_real <= '0;
                acc_imag <= '0;
            end else if (acc_en) begin
                acc_real <= acc_real + ACCUM_WIDTH'(pr_q);
                acc_imag <= acc_imag + ACCUM_WIDTH'(pi_q);
            end
        end
    end

endmodule

// File: rtl/dft_accumulation.sv
// Streaming DFT accumulator: frame FSM, windowing stage, last-flag pipeline and bin array.
module dft_accumulation
    import dft_pkg::*;
#(
    parameter int unsigned IQ_WIDTH           = IQ_W,
    parameter int unsigned WINDOW_WIDTH       = WIN_W,
    parameter int unsigned ACCUM_WIDTH        = ACC_W,
    parameter int unsigned OSC_WIDTH          = OSC_W,
    parameter int unsigned NUM_BINS           = BINS,
    parameter int unsigned SAMPLE_COUNT_WIDTH = CNT_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          sample_valid_i,
    input  logic                          last_sample_i,
    input  logic signed [IQ_WIDTH-1:0]    i_sample_i,
    input  logic signed [IQ_WIDTH-1:0]    q_sample_i,
    input  logic signed [WINDOW_WIDTH-1:0] window_coeff_i,
    input  logic signed [OSC_WIDTH-1:0]   W_real_i [NUM_BINS],
    input  logic signed [OSC_WIDTH-1:0]   W_imag_i [NUM_BINS],
    output logic signed [ACCUM_WIDTH-1:0] A_real_o [NUM_BINS],
    output logic signed [ACCUM_WIDTH-1:0] A_imag_o [NUM_BINS],
    output logic                          valid_o,
    output logic                          busy_o
);

    localparam int unsigned XW = IQ_WIDTH + 1;
    localparam int unsigned MW = IQ_WIDTH + WINDOW_WIDTH;
    localparam logic [SAMPLE_COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [SAMPLE_COUNT_WIDTH-1:0] CNT_LAST = {{(SAMPLE_COUNT_WIDTH-1){1'b1}}, 1'b0};

    state_t state, state_next;
    logic   busy_next, valid_next;

    logic signed [MW-1:0] i_full, q_full;
    logic signed [XW-1:0] xi_q, xq_q;
    logic                 accept, last_in;
    logic                 v0, v1, l0, l1;
    logic [SAMPLE_COUNT_WIDTH-1:0] count;

    // A full counter forces end of frame so the accumulator can never run unbounded.
    always_comb begin
        accept  = (state == ACCUM) && sample_valid_i && !start_i;
        last_in = accept && (last_sample_i || (count == CNT_LAST));
        i_full  = MW'(i_sample_i) * MW'(window_coeff_i);
        q_full  = MW'(q_sample_i) * MW'(window_coeff_i);
    end

    always_comb begin
        state_next = state;
        valid_next = 1'b0;
        unique case (state)
            IDLE:    if (start_i) state_next = ACCUM;
            ACCUM:   if (start_i) state_next = ACCUM;
                     else if (last_in) state_next = DRAIN;
            DRAIN:   if (start_i) state_next = ACCUM;
                     else if (l1) begin
                         state_next = IDLE;
                         valid_next = 1'b1;
                     end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            state   <= state_next;
            busy_o  <= busy_next;
            valid_o <= valid_next;
        end
    end

    // E0 windowing register plus valid/last flags that track the sample to E2.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xi_q  <= '0;
            xq_q  <= '0;
            v0    <= 1'b0;
            v1    <= 1'b0;
            l0    <= 1'b0;
            l1    <= 1'b0;
            count <= '0;
        end else begin
            if (accept) begin
                xi_q <= XW'(i_full >>> (WINDOW_WIDTH - 1));
                xq_q <= XW'(q_full >>> (WINDOW_WIDTH - 1));
            end
            v0 <= accept;
            l0 <= last_in;
            v1 <= v0 && !start_i;
            l1 <= l0 && !start_i;
            if (start_i)
                count <= '0;
            else if (accept && (count != CNT_MAX))
                count <= count + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
        dft_bin_mac #(
            .XW          (XW),
            .OSC_WIDTH   (OSC_WIDTH),
            .ACCUM_WIDTH (ACCUM_WIDTH)
        ) u_mac (
            .clk      (clk_i),
            .rst      (rst_i),
            .clear    (start_i),
            .load     (accept),
            .acc_en   (v1),
            .xi       (xi_q),
            .xq       (xq_q),
            .w_real   (W_real_i[k]),
            .w_imag   (W_imag_i[k]),
            .acc_real (A_real_o[k]),
            .acc_imag (A_imag_o[k])
        );
    end

endmodule

// File: tb/tb_dft_accumulation.sv
// Directed bench for dft_accumulation: hand-computed vectors plus a bit-exact tone model.
module tb_dft_accumulation;

    localparam int NB   = 24;
    localparam int ONE  = 33554432;   // 2^25, oscillator unity
    localparam int NTON = 256;

    logic clk = 1'b0;
    logic rst, start, svalid, slast;
    logic signed [15:0] isamp, qsamp, wcoef;
    logic signed [26:0] w_re [NB];
    logic signed [26:0] w_im [NB];
    logic signed [47:0] a_re [NB];
    logic signed [47:0] a_im [NB];
    logic valid, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc;
    bit saw_valid;
    longint exp_re [NB];
    longint exp_im [NB];

    always #5 clk = ~clk;

    dft_accumulation dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .sample_valid_i (svalid),
        .last_sample_i  (slast),
        .i_sample_i     (isamp),
        .q_sample_i     (qsamp),
        .window_coeff_i (wcoef),
        .W_real_i       (w_re),
        .W_imag_i       (w_im),
        .A_real_o       (a_re),
        .A_imag_o       (a_im),
        .valid_o        (valid),
        .busy_o         (busy)
    );

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_w();
        for (int k = 0; k < NB; k++) begin
            w_re[k] = '0;
            w_im[k] = '0;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic put(input int i, input int q, input int w, input bit last);
        isamp  = 16'(i);
        qsamp  = 16'(q);
        wcoef  = 16'(w);
        svalid = 1'b1;
        slast  = last;
    endtask

    // Last sample already driven: count edges until valid_o, bounded.
    task automatic finish_frame(output int n);
        step();
        svalid = 1'b0;
        slast  = 1'b0;
        n = 1;
        while (!valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic tone_frame(input bit gapped);
        real ph, x, y, win, c, s;
        longint xi, xq, wr, wi;
        int iv, qv, wv;
        for (int k = 0; k < NB; k++) begin
            exp_re[k] = 0;
            exp_im[k] = 0;
        end
        do_start();
        for (int n = 0; n < NTON; n++) begin
            ph  = 2.0 * 3.14159265358979 * real'(n) / real'(NTON);
            x   = 9000.0 * $cos(5.0 * ph) + 4000.0 * $cos(12.3 * ph + 0.4);
            y   = 9000.0 * $sin(5.0 * ph) - 3000.0 * $sin(17.0 * ph);
            win = 32767.0 * (0.5 - 0.5 * $cos(ph));
            iv  = int'(x);
            qv  = int'(y);
            wv  = int'(win);
            xi  = (longint'(iv) * longint'(wv)) >>> 15;
            xq  = (longint'(qv) * longint'(wv)) >>> 15;
            for (int k = 0; k < NB; k++) begin
                c  = $cos(real'(k) * ph);
                s  = $sin(real'(k) * ph);
                wr = longint'(int'(real'(ONE) * c));
                wi = -longint'(int'(real'(ONE) * s));
                w_re[k] = 27'(wr);
                w_im[k] = 27'(wi);
                exp_re[k] += (xi * wr - xq * wi) >>> 25;
                exp_im[k] += (xi * wi + xq * wr) >>> 25;
            end
            put(iv, qv, wv, n == NTON - 1);
            if (n < NTON - 1) begin
                step();
                if (gapped) begin
                    svalid = 1'b0;
                    step();
                end
            end
        end
        finish_frame(ncyc);
        chk(gapped ? "tone_gap_latency" : "tone_latency", ncyc, 3);
        for (int k = 0; k < NB; k++) begin
            chk($sformatf("%s_re[%0d]", gapped ? "gap" : "tone", k), a_re[k], exp_re[k]);
            chk($sformatf("%s_im[%0d]", gapped ? "gap" : "tone", k), a_im[k], exp_im[k]);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; svalid = 1'b0; slast = 1'b0;
        isamp = '0; qsamp = '0; wcoef = '0;
        clear_w();
        step(); step();
        chk("rst_a_re0", a_re[0], 0);
        chk("rst_a_im5", a_im[5], 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        rst = 1'b0;

        // Samples without start are ignored.
        w_re[0] = 27'(ONE);
        saw_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            put(16384, 0, 32767, n == 3);
            step();
            if (valid) saw_valid = 1'b1;
        end
        svalid = 1'b0; slast = 1'b0;
        step(); step(); step();
        chk("idle_no_valid", saw_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_a_re0", a_re[0], 0);

        // DC into bin 0, negated into bin 1, imaginary oscillator on bin 2.
        clear_w();
        w_re[0] = 27'(ONE);
        w_re[1] = 27'(-ONE);
        w_im[2] = 27'(ONE);
        do_start();
        chk("dc_busy_after_start", busy, 1);
        chk("dc_a_zero_after_start", a_re[0], 0);
        for (int n = 0; n < 4; n++) begin
            put(16384, 0, 32767, n == 3);
            if (n < 3) step();
        end
        finish_frame(ncyc);
        chk("dc_latency", ncyc, 3);
        chk("dc_busy_at_valid", busy, 0);
        chk("dc_re0", a_re[0], 65532);
        chk("dc_im0", a_im[0], 0);
        chk("dc_re1", a_re[1], -65532);
        chk("dc_re2", a_re[2], 0);
        chk("dc_im2", a_im[2], 65532);
        step();
        chk("dc_valid_one_cycle", valid, 0);
        chk("dc_hold_re0", a_re[0], 65532);

        // Rotation by j; bin 1 exercises floor of a tiny negative product.
        clear_w();
        w_im[0] = 27'(ONE);
        w_im[1] = 27'(1);
        do_start();
        put(0, 1000, 32767, 1'b1);
        finish_frame(ncyc);
        chk("rot_latency", ncyc, 3);
        chk("rot_re0", a_re[0], -999);
        chk("rot_im0", a_im[0], 0);
        chk("rot_re1", a_re[1], -1);
        chk("rot_im1", a_im[1], 0);

        // Frame aborted by start (with a colliding sample), then a clean frame.
        clear_w();
        w_re[0] = 27'(ONE);
        do_start();
        saw_valid = 1'b0;
        put(16384, 0, 32767, 1'b0); step();
        put(16384, 0, 32767, 1'b0); step();
        start = 1'b1;
        put(16384, 0, 32767, 1'b1);
        step();
        start = 1'b0; svalid = 1'b0; slast = 1'b0;
        chk("abort_a_cleared", a_re[0], 0);
        chk("abort_busy", busy, 1);
        for (int n = 0; n < 5; n++) begin
            step();
            if (valid) saw_valid = 1'b1;
        end
        chk("abort_no_valid", saw_valid, 0);
        chk("abort_pipe_flushed", a_re[0], 0);
        put(16384, 0, 32767, 1'b0); step();
        put(-1, 0, 32767, 1'b1);
        finish_frame(ncyc);
        chk("restart_latency", ncyc, 3);
        chk("restart_re0", a_re[0], 16382);

        // Back-to-back frame starts from zero.
        do_start();
        put(-1, 0, 32767, 1'b1);
        finish_frame(ncyc);
        chk("b2b_re0", a_re[0], -1);

        tone_frame(1'b0);
        tone_frame(1'b1);

        // Reset mid-frame aborts without valid_o.
        do_start();
        put(16384, 0, 32767, 1'b0); step();
        svalid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_busy", busy, 0);
        chk("midrst_re0", a_re[0], 0);
        rst = 1'b0;
        step(); step(); step();
        chk("midrst_no_valid", valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
